// File: rtl/vpu_fp_exp_result_buffer_if.sv
// Handshake bundle between the exp-unit result buffer, its request source, the exp IP and the destination port.
interface vpu_fp_exp_result_buffer_if #(
    parameter int DATA_W = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  issue_o;
    logic                  res_valid_i;
    logic [2*DATA_W-1:0]   res_data_i;
    logic [DATA_W-1:0]     result_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  overflow_o;

    modport master (
        output req_valid_i, res_valid_i, res_data_i, ready_i,
        input  req_ready_o, issue_o, result_o, valid_o, overflow_o
    );

    modport slave (
        input  req_valid_i, res_valid_i, res_data_i, ready_i,
        output req_ready_o, issue_o, result_o, valid_o, overflow_o
    );
endinterface

// File: rtl/vpu_fp_exp_result_buffer.sv
// Exp-unit result buffer: credit-limited issue, fp32->bf16 (RNE if VPU_EXP_RNE_EN, else truncate), DEPTH-entry FIFO.
// Latency: valid_o rises one cycle after res_valid_i; results are discarded for FLUSH_CYC cycles after reset.
// Backpressure: ready_i stalls the FIFO head; issue stops at DEPTH outstanding so the exp unit never stalls.
module vpu_fp_exp_result_buffer #(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 16,
    parameter int FLUSH_CYC = 32
) (
    input  logic clk,
    input  logic rst_n,
    vpu_fp_exp_result_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FC_W  = $clog2(FLUSH_CYC + 1);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [FC_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              overflow;

    logic              run;
    logic              issue;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] upper;
    logic [DATA_W-1:0] conv;

    assign run      = (state == ST_RUN);
    assign issue    = bus.req_valid_i & bus.req_ready_o;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = !empty & bus.ready_i;
    assign push_req = run & bus.res_valid_i;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push     = push_req & (!full | pop);
    assign drop     = push_req & full & !pop;

    assign bus.req_ready_o = run & (outstanding < CNT_W'(DEPTH));
    assign bus.issue_o     = issue;
    assign bus.valid_o     = !empty;
    assign bus.result_o    = empty ? '0 : mem[rd_ptr];
    assign bus.overflow_o  = overflow;

    assign upper = bus.res_data_i[2*DATA_W-1:DATA_W];

`ifdef VPU_EXP_RNE_EN
    logic guard;
    logic sticky;
    logic lsb;
    logic is_nan;

    assign guard  = bus.res_data_i[DATA_W-1];
    assign sticky = |bus.res_data_i[DATA_W-2:0];
    assign lsb    = bus.res_data_i[DATA_W];
    assign is_nan = (&bus.res_data_i[30:23]) & (|bus.res_data_i[22:0]);
    // NaNs are forced quiet instead of rounded, so they can never collapse into inf.
    assign conv   = is_nan ? (upper | DATA_W'(16'h0040))
                           : upper + DATA_W'(guard & (sticky | lsb));
`else
    logic unused_low;

    assign unused_low = ^bus.res_data_i[DATA_W-1:0];
    assign conv       = upper;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: result_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= conv;
        end
    end
endmodule

// File: doc/vpu_fp_exp_result_buffer.md
Name: vpu_fp_exp_result_buffer

Overview:
- Downstream companion of the VPU FP exponential unit, between that unit and the VPU destination port.
- The exp IP has a fixed pipeline latency, no backpressure and no reset. This block issues credit-limited start pulses to it, captures every 32-bit result, converts it to a 16-bit bf16 operand, and buffers it in a FIFO.
- Results leave through a valid/ready interface.

Parameters:
- DEPTH, 8: FIFO entries and maximum outstanding operations; power of two, ≥2.
- DATA_W, 16: output operand width; equals VPU_PKG::OPERAND_WIDTH.
- FLUSH_CYC, 32: cycles after reset during which exp results are discarded; must be ≥ exp IP latency.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req_valid_i, input, 1: source port requests an exp operation.
- req_ready_o, output, 1: the request can be issued this cycle.
- issue_o, output, 1: start pulse to the exp unit; equals req_valid_i & req_ready_o (combinational).
- res_valid_i, input, 1: exp unit result valid (done).
- res_data_i, input, 2*DATA_W: exp unit fp32 result.
- result_o, output, DATA_W: head-of-FIFO bf16 result.
- valid_o, output, 1: result_o is valid.
- ready_i, input, 1: destination port accepts result_o.
- overflow_o, output, 1: sticky error; a result arrived while the FIFO was full.

Behaviour:
- Reset values: state=FLUSH, flush counter 0, outstanding 0, FIFO empty. Therefore req_ready_o=0, valid_o=0, overflow_o=0, result_o=0.
- FSM FLUSH:
  - req_ready_o=0.
  - res_valid_i is ignored; pre-reset pipeline contents are discarded.
  - Counter increments each cycle; when it reaches FLUSH_CYC-1, go to RUN next cycle.
- FSM RUN: normal operation; stays in RUN until reset.
- Outstanding counter, width clog2(DEPTH+1):
  - Counts issued results not yet popped.
  - Increment on issue_o; decrement on pop (valid_o & ready_i); both in the same cycle leaves it unchanged.
  - req_ready_o = (state==RUN) & (outstanding < DEPTH).
  - Consequence: the FIFO can never overflow in correct operation.
- FIFO push: res_valid_i in RUN.
  - Pushes the converted value.
  - If full and no pop that cycle: drop the value, set overflow_o (cleared only by reset).
  - Full with a simultaneous pop: the push is accepted.
- FIFO pop: valid_o & ready_i.
  - valid_o = !empty, registered state with no bypass.
  - res_valid_i at cycle N into an empty FIFO gives valid_o=1 at N+1.
  - Pointers wrap modulo DEPTH; DEPTH consecutive pushes followed by DEPTH pops return the data in order.
- Conversion (applied at push): res_data_i[2*DATA_W-1:DATA_W] per Optional Feature; stored as DATA_W bits.
- valid_o held with ready_i=0: result_o must remain stable.
- Reset mid-operation: all state returns to reset values immediately (async). Buffered and in-flight results are lost; the flush window absorbs late exp results.

Optional Feature:
- Macro: VPU_EXP_RNE_EN.
- Defined: round-to-nearest-even.
  - upper = d[31:16], guard = d[15], sticky = |d[14:0], lsb = d[16].
  - Output = upper + (guard & (sticky | lsb)); a carry into the exponent yields ±inf.
  - NaN input (exponent all ones, mantissa nonzero): output = upper | 16'h0040 (quiet NaN, never rounds to inf).
- Undefined: truncation, output = d[31:16].

Test Plan:
- Reset, hold req_valid_i=1 → req_ready_o=0 for exactly FLUSH_CYC cycles, then 1; res_valid_i pulses during flush → no push, valid_o stays 0.
- RUN, res_data_i=0x3F800000 at cycle N → valid_o=1, result_o=0x3F80 at N+1; 0x3F818000 → 0x3F82 with VPU_EXP_RNE_EN, 0x3F81 without.
- Rounding corners with VPU_EXP_RNE_EN:
  - 0x3F808000 → 0x3F80 (tie to even).
  - 0x7F7FFFFF → 0x7F80.
  - 0x7F800001 → 0x7FC0.
- Credit limit: ready_i=0, req_valid_i=1 → exactly 8 issue_o pulses, then req_ready_o=0. Return 8 results, pop 1 → req_ready_o=1 the next cycle. Results are popped in order, overflow_o=0.
- Full FIFO plus simultaneous pop and push → count stays 8, no overflow. Forced extra res_valid_i while full with no pop → overflow_o=1 sticky until rst_n.
- Assert rst_n=0 with 5 entries buffered → valid_o, req_ready_o and outstanding drop to 0 asynchronously; the FSM re-enters FLUSH.
